// File: rtl/reg_file_scoreboard.sv
// Architectural-state self-check engine: scans NUM_REGS entries and compares actual against
// expected values under a per-bit mask, reporting error count, first mismatch and pass/fail.
module reg_file_scoreboard #(
    parameter int unsigned NUM_REGS = 38,
    parameter int unsigned DATA_W   = 34,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              stop_on_err,
    input  logic [DATA_W-1:0] cmp_mask,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] act_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_valid,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_act,
    output logic [DATA_W-1:0] first_err_exp
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

    state_e            state_q;
    logic              stop_mode_q;
    logic [DATA_W-1:0] mask_q;
    logic              halted_q;
    logic              pipe_v_q   [READ_LAT];
    logic [IDX_W-1:0]  pipe_idx_q [READ_LAT];

    logic             cmp_valid;
    logic             mismatch;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_flight;

    always_comb begin
        // Once halted, returns still in the pipe are drained but never compared.
        cmp_valid = pipe_v_q[READ_LAT-1] && !halted_q;
        mismatch  = cmp_valid && (((act_data ^ exp_data) & mask_q) != '0);
        cnt_inc   = (err_count == '1) ? err_count : err_count + CNT_W'(1);
        // Anything that will still occupy the pipe after the coming edge.
        in_flight = rd_en;
        for (int i = 0; i < int'(READ_LAT) - 1; i++) begin
            in_flight = in_flight | pipe_v_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= StIdle;
            stop_mode_q   <= 1'b0;
            mask_q        <= '0;
            halted_q      <= 1'b0;
            rd_en         <= 1'b0;
            rd_idx        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            err_valid     <= 1'b0;
            first_err_idx <= '0;
            first_err_act <= '0;
            first_err_exp <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                pipe_v_q[i]   <= 1'b0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0]   <= rd_en;
            pipe_idx_q[0] <= rd_idx;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
            done <= 1'b0;

            if (mismatch) begin
                err_count <= cnt_inc;
                if (!err_valid) begin
                    err_valid     <= 1'b1;
                    first_err_idx <= pipe_idx_q[READ_LAT-1];
                    first_err_act <= act_data;
                    first_err_exp <= exp_data;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        stop_mode_q   <= stop_on_err;
                        mask_q        <= cmp_mask;
                        halted_q      <= 1'b0;
                        err_count     <= '0;
                        err_valid     <= 1'b0;
                        first_err_idx <= '0;
                        first_err_act <= '0;
                        first_err_exp <= '0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        rd_en         <= 1'b1;
                        rd_idx        <= '0;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (mismatch && stop_mode_q) begin
                        rd_en    <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= StDrain;
                    end else if (rd_idx == LastIdx) begin
                        rd_en   <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                StDrain: begin
                    if (mismatch && stop_mode_q) begin
                        halted_q <= 1'b1;
                    end
                    if (!in_flight) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= !mismatch && (err_count == '0);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
